// File: rtl/fc1_intstat_bank_pkg.sv
// Shared constants and CSR view for the FC1 interval-statistics bank.
package fc1_intstat_bank_pkg;
   localparam int FC1_INTSTAT_MAX_CH = 32;
   localparam int FC1_INTSTAT_ADDR_W = 5;

   // 32-bit CSR word: saturation flag on top, zero-extended count below
   typedef struct packed {
      logic        sat;
      logic [30:0] cnt;
   } fc1_intstat_rd_t;
endpackage

// File: rtl/fc1_intstat_bank_if.sv
// Indexed read port of the statistics bank (requester = master).
interface fc1_intstat_bank_if
   import fc1_intstat_bank_pkg::*;
#(
   parameter int OUT_W = 32
);
   logic                          rd_req;
   logic [FC1_INTSTAT_ADDR_W-1:0] rd_addr;
   logic                          rd_vld;
   logic [OUT_W-1:0]              rd_data;

   modport master (output rd_req, output rd_addr, input rd_vld, input rd_data);
   modport slave  (input rd_req, input rd_addr, output rd_vld, output rd_data);
endinterface

// File: rtl/fc1_intstat_ctr.sv
// One channel: saturating running count plus its interval snapshot.
module fc1_intstat_ctr #(
   parameter int CTR_W = 16,
   parameter int INC_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             latch_clr_i,
   input  logic             en_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [CTR_W-1:0] lat_cnt_o,
   output logic             lat_sat_o
);
   // sum is wide enough that neither operand ever truncates, so no wrap
   localparam int SW = (CTR_W + 1 > INC_W + 1) ? CTR_W + 1 : INC_W + 1;
   localparam logic [CTR_W-1:0] MAX = '1;

   logic [CTR_W-1:0] acc_q, acc_d, lat_cnt_q, lat_cnt_d, clamp;
   logic             sat_q, sat_d, lat_sat_q, lat_sat_d, hit;
   logic [SW-1:0]    sum, inc_x;

   // saturating add; the latch cycle's increment belongs to the closing interval
   always_comb begin
      inc_x     = en_i ? SW'(inc_i) : '0;
      sum       = SW'(acc_q) + inc_x;
      hit       = (sum >= SW'(MAX));
      clamp     = hit ? MAX : sum[CTR_W-1:0];
      acc_d     = clamp;
      sat_d     = sat_q | hit;
      lat_cnt_d = lat_cnt_q;
      lat_sat_d = lat_sat_q;
      if (latch_clr_i) begin
         lat_cnt_d = clamp;
         lat_sat_d = sat_q | hit;
         acc_d     = '0;
         sat_d     = 1'b0;
      end
   end

   // channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         sat_q     <= 1'b0;
         lat_cnt_q <= '0;
         lat_sat_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         sat_q     <= sat_d;
         lat_cnt_q <= lat_cnt_d;
         lat_sat_q <= lat_sat_d;
      end
   end

   assign lat_cnt_o = lat_cnt_q;
   assign lat_sat_o = lat_sat_q;
endmodule

// File: rtl/fc1_intstat_bank.sv
// N-channel interval statistics bank: per-channel counters, snapshot strobe, CSR read port.
module fc1_intstat_bank
   import fc1_intstat_bank_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int CTR_W  = 16,
   parameter int INC_W  = 2,
   parameter int OUT_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      latch_clr,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH*INC_W-1:0]   inc,
   output logic [NUM_CH*CTR_W-1:0]   lat_cnt,
   output logic [NUM_CH-1:0]         lat_sat,
   output logic                      lat_vld,
   fc1_intstat_bank_if.slave         rd
);
   logic [CTR_W-1:0] cnt_a [NUM_CH];
   logic             lat_vld_q;
   logic             rd_vld_q, rd_vld_d;
   logic [OUT_W-1:0] rd_data_q, rd_data_d, rd_word;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fc1_intstat_ctr #(.CTR_W(CTR_W), .INC_W(INC_W)) u_ctr (
         .clk         (clk),
         .rst_n       (rst_n),
         .latch_clr_i (latch_clr),
         .en_i        (ch_en[g]),
         .inc_i       (inc[g*INC_W +: INC_W]),
         .lat_cnt_o   (cnt_a[g]),
         .lat_sat_o   (lat_sat[g])
      );
      assign lat_cnt[g*CTR_W +: CTR_W] = cnt_a[g];
   end

   // read mux over the current snapshot; out-of-range index yields zero
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd.rd_addr == FC1_INTSTAT_ADDR_W'(i)) begin
            rd_word[CTR_W-1:0] = cnt_a[i];
            rd_word[OUT_W-1]   = lat_sat[i];
         end
      end
      rd_vld_d  = rd.rd_req;
      rd_data_d = rd.rd_req ? rd_word : rd_data_q;
   end

   // snapshot strobe and registered read response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_vld_q <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         lat_vld_q <= latch_clr;
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign lat_vld    = lat_vld_q;
   assign rd.rd_vld  = rd_vld_q;
   assign rd.rd_data = rd_data_q;
endmodule

// File: tb/tb_fc1_intstat_bank.sv
// Directed bench for fc1_intstat_bank with CTR_W=8 so saturation is reachable.
module tb_fc1_intstat_bank;
   import fc1_intstat_bank_pkg::*;

   localparam int NUM_CH = 8;
   localparam int CTR_W  = 8;
   localparam int INC_W  = 2;
   localparam int OUT_W  = 32;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    latch_clr = 1'b0;
   logic [NUM_CH-1:0]       ch_en = '1;
   logic [NUM_CH*INC_W-1:0] inc = '0;
   logic [NUM_CH*CTR_W-1:0] lat_cnt;
   logic [NUM_CH-1:0]       lat_sat;
   logic                    lat_vld;
   int                      total = 0;
   int                      bad = 0;
   fc1_intstat_rd_t         rv;

   fc1_intstat_bank_if #(.OUT_W(OUT_W)) rd_if ();

   fc1_intstat_bank #(.NUM_CH(NUM_CH), .CTR_W(CTR_W), .INC_W(INC_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .latch_clr (latch_clr),
      .ch_en     (ch_en),
      .inc       (inc),
      .lat_cnt   (lat_cnt),
      .lat_sat   (lat_sat),
      .lat_vld   (lat_vld),
      .rd        (rd_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [CTR_W-1:0] cnt_of(input int ch);
      return lat_cnt[ch*CTR_W +: CTR_W];
   endfunction

   task automatic set_inc(input int ch, input logic [INC_W-1:0] v);
      inc[ch*INC_W +: INC_W] = v;
   endtask

   initial begin
      rd_if.rd_req  = 1'b0;
      rd_if.rd_addr = '0;

      // 1: reset state and empty interval
      #2;
      chk("rst_lat_cnt", lat_cnt, 0);
      chk("rst_lat_sat", lat_sat, 0);
      chk("rst_lat_vld", lat_vld, 0);
      chk("rst_rd_vld",  rd_if.rd_vld, 0);
      chk("rst_rd_data", rd_if.rd_data, 0);
      tick(2);
      rst_n = 1'b1;
      tick(9);
      chk("t1_vld_before", lat_vld, 0);
      latch_clr = 1'b1;
      tick();
      latch_clr = 1'b0;
      chk("t1_vld", lat_vld, 1);
      chk("t1_cnt", lat_cnt, 0);
      chk("t1_sat", lat_sat, 0);
      tick();
      chk("t1_vld_drop", lat_vld, 0);

      // 2: saturation on ch0, then a clean interval
      set_inc(0, 2'd3);
      tick(100);
      set_inc(0, 2'd0);
      latch_clr = 1'b1;
      tick();
      latch_clr = 1'b0;
      chk("t2_cnt0", cnt_of(0), 255);
      chk("t2_sat0", lat_sat[0], 1);
      rd_if.rd_req = 1'b1; rd_if.rd_addr = 5'd0;
      tick();
      rd_if.rd_req = 1'b0;
      chk("t2_rd_vld", rd_if.rd_vld, 1);
      chk("t2_rd_data", rd_if.rd_data, 32'h8000_00FF);
      rv = rd_if.rd_data;
      chk("t2_rd_sat", rv.sat, 1);
      tick(5);
      latch_clr = 1'b1;
      tick();
      latch_clr = 1'b0;
      chk("t2_cnt0_clear", cnt_of(0), 0);
      chk("t2_sat0_clear", lat_sat[0], 0);

      // 3: latch-cycle increment counts in closing interval
      set_inc(1, 2'd1);
      tick(4);
      latch_clr = 1'b1;
      tick();
      latch_clr = 1'b0;
      chk("t3_cnt1", cnt_of(1), 5);
      tick();
      set_inc(1, 2'd0);
      latch_clr = 1'b1;
      tick();
      latch_clr = 1'b0;
      chk("t3_cnt1_next", cnt_of(1), 1);

      // back-to-back latch: second snapshot is just its own cycle's increment
      set_inc(3, 2'd2);
      latch_clr = 1'b1;
      tick();
      chk("b2b_cnt3_a", cnt_of(3), 2);
      chk("b2b_vld_a", lat_vld, 1);
      set_inc(3, 2'd1);
      tick();
      latch_clr = 1'b0;
      set_inc(3, 2'd0);
      chk("b2b_cnt3_b", cnt_of(3), 1);
      chk("b2b_vld_b", lat_vld, 1);
      tick();
      chk("b2b_vld_drop", lat_vld, 0);

      // 4: disabled channel holds, others count
      ch_en = 8'hFB;
      set_inc(2, 2'd2); set_inc(4, 2'd2); set_inc(1, 2'd1);
      tick(20);
      set_inc(2, 2'd0); set_inc(4, 2'd0); set_inc(1, 2'd0);
      latch_clr = 1'b1;
      tick();
      latch_clr = 1'b0;
      ch_en = '1;
      chk("t4_cnt2_off", cnt_of(2), 0);
      chk("t4_cnt4", cnt_of(4), 40);
      chk("t4_cnt1", cnt_of(1), 20);

      // 5: read coincident with latch returns the old snapshot
      set_inc(1, 2'd3);
      tick(3);
      set_inc(1, 2'd0);
      latch_clr = 1'b1;
      rd_if.rd_req = 1'b1; rd_if.rd_addr = 5'd1;
      tick();
      latch_clr = 1'b0;
      rd_if.rd_req = 1'b0;
      chk("t5_rd_old", rd_if.rd_data, 20);
      chk("t5_rd_vld", rd_if.rd_vld, 1);
      tick();
      chk("t5_rd_idle_vld", rd_if.rd_vld, 0);
      chk("t5_rd_hold", rd_if.rd_data, 20);
      rd_if.rd_req = 1'b1;
      tick();
      chk("t5_rd_new", rd_if.rd_data, 9);
      rd_if.rd_addr = 5'(NUM_CH);
      tick();
      rd_if.rd_req = 1'b0;
      chk("t5_oor_data", rd_if.rd_data, 0);
      chk("t5_oor_vld", rd_if.rd_vld, 1);

      // 6: async reset mid-interval discards acc and snapshot
      set_inc(0, 2'd2);
      tick(20);
      set_inc(0, 2'd0);
      chk("t6_pre_cnt1", cnt_of(1), 9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cnt", lat_cnt, 0);
      chk("t6_rst_sat", lat_sat, 0);
      chk("t6_rst_rd_vld", rd_if.rd_vld, 0);
      tick();
      rst_n = 1'b1;
      set_inc(0, 2'd1);
      tick(3);
      set_inc(0, 2'd0);
      chk("t6_vld_before", lat_vld, 0);
      latch_clr = 1'b1;
      tick();
      latch_clr = 1'b0;
      chk("t6_cnt0", cnt_of(0), 3);
      chk("t6_vld", lat_vld, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
